main_control_fsm: RTL and testbench

Multicycle main control unit for the RISC datapath. It is the producer of the `opcode`/`sel` inputs consumed by `alu_control`, which turns them plus `funct` into `alu_cnt`. It sequences each instruction through fetch, decode, execute, memory and writeback states, and drives every datapath mux, register-write and memory strobe. Memory accesses wait on a single-bit ready handshake.

---
 rtl/main_control_fsm_pkg.sv | 78 +++++++
 rtl/main_control_fsm_if.sv | 36 +++
 rtl/main_control_fsm_decode.sv | 88 ++++++++
 rtl/main_control_fsm.sv | 74 +++++++
 tb/tb_main_control_fsm.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/main_control_fsm_pkg.sv
// Shared encodings for the multicycle RISC control path: FSM states, opcodes,
// ALU/mux select values and the bundled control-output record.
package risc_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_INIT     = 4'd0,
    ST_FETCH    = 4'd1,
    ST_DECODE   = 4'd2,
    ST_EXEC_R   = 4'd3,
    ST_R_WB     = 4'd4,
    ST_EXEC_I   = 4'd5,
    ST_I_WB     = 4'd6,
    ST_MEM_ADDR = 4'd7,
    ST_MEM_RD   = 4'd8,
    ST_MEM_WB   = 4'd9,
    ST_MEM_WR   = 4'd10,
    ST_BRANCH   = 4'd11,
    ST_JUMP     = 4'd12,
    ST_ILLEGAL  = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  // alu_op values are also decoded by alu_control; keep the two in step.
  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT = 2'b10;
  localparam logic [1:0] ALU_OP_IMM   = 2'b11;

  localparam logic [1:0] SRC_B_REG     = 2'b00;
  localparam logic [1:0] SRC_B_FOUR    = 2'b01;
  localparam logic [1:0] SRC_B_IMM     = 2'b10;
  localparam logic [1:0] SRC_B_IMM_SH2 = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  typedef struct packed {
    logic [1:0] alu_op;
    logic       alu_sel;
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  // DECODE dispatch: unknown opcodes fall into ILLEGAL.
  function automatic state_t decode_target(input logic [5:0] op);
    state_t nxt;
    case (op)
      OP_R:           nxt = ST_EXEC_R;
      OP_LW, OP_SW:   nxt = ST_MEM_ADDR;
      OP_BEQ:         nxt = ST_BRANCH;
      OP_J:           nxt = ST_JUMP;
      OP_ADDI, OP_ORI: nxt = ST_EXEC_I;
      default:        nxt = ST_ILLEGAL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// Control bundle between the main control FSM (master) and the datapath (slave).
// Handshake: mem_ready is a single-cycle completion flag; an access in FETCH, MEM_RD or MEM_WR finishes in the cycle mem_ready is 1, otherwise it holds.
interface main_control_fsm_if;
  logic [5:0] op;
  logic       mem_ready;
  logic [1:0] alu_op;
  logic       alu_sel;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  op, mem_ready,
    output alu_op, alu_sel, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           pc_source, instr_done, illegal_op
  );

  modport slave (
    output op, mem_ready,
    input  alu_op, alu_sel, pc_write, pc_write_cond, i_or_d, mem_read, mem_write,
           ir_write, mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b,
           pc_source, instr_done, illegal_op
  );
endinterface

// File: rtl/main_control_fsm_decode.sv
// Combinational output decode: current state plus latched opcode and mem_ready
// produce every datapath strobe and select.
module main_ctrl_decode
  import risc_ctrl_pkg::*;
(
  input  state_t     state,
  input  logic [5:0] op_q,
  input  logic       mem_ready,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRC_B_FOUR;
        ctrl.alu_op    = ALU_OP_ADD;
        ctrl.pc_source = PC_SRC_ALU;
        // IR load and PC+4 only commit in the cycle the fetch completes.
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      ST_DECODE: begin
        ctrl.alu_src_b = SRC_B_IMM_SH2;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_EXEC_R: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_REG;
        ctrl.alu_op    = ALU_OP_FUNCT;
      end
      ST_R_WB: begin
        ctrl.reg_dst    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_EXEC_I: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_IMM;
        ctrl.alu_sel   = (op_q == OP_ORI);
      end
      ST_I_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_ADDR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRC_B_IMM;
        ctrl.alu_op    = ALU_OP_ADD;
      end
      ST_MEM_RD: begin
        ctrl.mem_read = 1'b1;
        ctrl.i_or_d   = 1'b1;
      end
      ST_MEM_WB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      ST_MEM_WR: begin
        ctrl.mem_write  = 1'b1;
        ctrl.i_or_d     = 1'b1;
        ctrl.instr_done = mem_ready;
      end
      ST_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_src_b     = SRC_B_REG;
        ctrl.alu_op        = ALU_OP_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PC_SRC_ALUOUT;
        ctrl.instr_done    = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_write   = 1'b1;
        ctrl.pc_source  = PC_SRC_JUMP;
        ctrl.instr_done = 1'b1;
      end
      ST_ILLEGAL: begin
        ctrl.illegal_op = 1'b1;
        ctrl.instr_done = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/main_control_fsm.sv
// Multicycle main control unit: state register, opcode latch and next-state
// logic; outputs come from main_ctrl_decode. The state is exposed on dbg_state.
module main_control_fsm
  import risc_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  main_control_fsm_if.master    bus,
  output state_t                dbg_state
);

  state_t     state_q, state_d;
  logic [5:0] op_q, op_d;
  ctrl_t      ctrl;

  always_comb begin
    state_d = state_q;
    op_d    = (state_q == ST_DECODE) ? bus.op : op_q;
    case (state_q)
      ST_INIT:     state_d = ST_FETCH;
      ST_FETCH:    state_d = bus.mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:   state_d = decode_target(bus.op);
      ST_EXEC_R:   state_d = ST_R_WB;
      ST_R_WB:     state_d = ST_FETCH;
      ST_EXEC_I:   state_d = ST_I_WB;
      ST_I_WB:     state_d = ST_FETCH;
      // Only lw/sw reach MEM_ADDR, so anything other than lw is a store.
      ST_MEM_ADDR: state_d = (op_q == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      ST_MEM_RD:   state_d = bus.mem_ready ? ST_MEM_WB : ST_MEM_RD;
      ST_MEM_WB:   state_d = ST_FETCH;
      ST_MEM_WR:   state_d = bus.mem_ready ? ST_FETCH : ST_MEM_WR;
      ST_BRANCH:   state_d = ST_FETCH;
      ST_JUMP:     state_d = ST_FETCH;
      ST_ILLEGAL:  state_d = ST_FETCH;
      default:     state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_INIT;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
    end
  end

  main_ctrl_decode u_decode (
    .state     (state_q),
    .op_q      (op_q),
    .mem_ready (bus.mem_ready),
    .ctrl      (ctrl)
  );

  assign bus.alu_op        = ctrl.alu_op;
  assign bus.alu_sel       = ctrl.alu_sel;
  assign bus.pc_write      = ctrl.pc_write;
  assign bus.pc_write_cond = ctrl.pc_write_cond;
  assign bus.i_or_d        = ctrl.i_or_d;
  assign bus.mem_read      = ctrl.mem_read;
  assign bus.mem_write     = ctrl.mem_write;
  assign bus.ir_write      = ctrl.ir_write;
  assign bus.mem_to_reg    = ctrl.mem_to_reg;
  assign bus.reg_dst       = ctrl.reg_dst;
  assign bus.reg_write     = ctrl.reg_write;
  assign bus.alu_src_a     = ctrl.alu_src_a;
  assign bus.alu_src_b     = ctrl.alu_src_b;
  assign bus.pc_source     = ctrl.pc_source;
  assign bus.instr_done    = ctrl.instr_done;
  assign bus.illegal_op    = ctrl.illegal_op;
  assign dbg_state         = state_q;

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed bench for main_control_fsm: one task per scenario, inline checks,
// cycle 1 of each instruction is the FETCH entry cycle.
module tb_main_control_fsm;
  import risc_ctrl_pkg::*;

  logic   clk = 1'b0;
  logic   rst;
  state_t dbg_state;
  int     total = 0;
  int     bad = 0;

  main_control_fsm_if bus();

  main_control_fsm dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  logic [18:0] all_outs;
  assign all_outs = {bus.alu_op, bus.alu_sel, bus.pc_write, bus.pc_write_cond,
                     bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
                     bus.mem_to_reg, bus.reg_dst, bus.reg_write, bus.alu_src_a,
                     bus.alu_src_b, bus.pc_source, bus.instr_done, bus.illegal_op};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.op = OP_SW;
    bus.mem_ready = 1'b1;
    tick();
    tick();
    total++;
    if (dbg_state !== ST_INIT) begin
      bad++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, ST_INIT);
    end
    total++;
    if (all_outs !== 19'h0) begin
      bad++; $display("FAIL reset_outs got=%h exp=0", all_outs);
    end
    rst = 1'b0;
    tick();
    total++;
    if (dbg_state !== ST_FETCH) begin
      bad++; $display("FAIL init_to_fetch got=%0d exp=%0d", dbg_state, ST_FETCH);
    end
  endtask

  task automatic test_r_type();
    int done_cnt = 0;
    bus.op = OP_R;
    bus.mem_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      if (bus.instr_done === 1'b1) done_cnt++;
      case (c)
        1: begin
          total++;
          if ({bus.mem_read, bus.ir_write, bus.pc_write, bus.alu_src_b, bus.alu_op} !== 7'b1110100) begin
            bad++; $display("FAIL r_fetch got=%b exp=1110100",
                            {bus.mem_read, bus.ir_write, bus.pc_write, bus.alu_src_b, bus.alu_op});
          end
        end
        2: begin
          total++;
          if (dbg_state !== ST_DECODE || bus.alu_src_b !== 2'b11) begin
            bad++; $display("FAIL r_decode state=%0d src_b=%b exp state=%0d src_b=11",
                            dbg_state, bus.alu_src_b, ST_DECODE);
          end
        end
        3: begin
          total++;
          if (dbg_state !== ST_EXEC_R || {bus.alu_op, bus.alu_src_a, bus.alu_src_b} !== 5'b10100) begin
            bad++; $display("FAIL r_exec state=%0d bits=%b exp state=%0d bits=10100",
                            dbg_state, {bus.alu_op, bus.alu_src_a, bus.alu_src_b}, ST_EXEC_R);
          end
        end
        default: begin
          total++;
          if (dbg_state !== ST_R_WB || {bus.reg_write, bus.reg_dst, bus.mem_to_reg} !== 3'b110) begin
            bad++; $display("FAIL r_wb state=%0d bits=%b exp state=%0d bits=110",
                            dbg_state, {bus.reg_write, bus.reg_dst, bus.mem_to_reg}, ST_R_WB);
          end
        end
      endcase
      tick();
    end
    total++;
    if (done_cnt !== 1) begin
      bad++; $display("FAIL r_done_count got=%0d exp=1", done_cnt);
    end
    total++;
    if (dbg_state !== ST_FETCH) begin
      bad++; $display("FAIL r_back_to_fetch got=%0d exp=%0d", dbg_state, ST_FETCH);
    end
  endtask

  task automatic test_lw_waits();
    int ir_cnt = 0;
    int done_cnt = 0;
    int done_c = 0;
    logic mtr = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      bus.op = OP_LW;
      bus.mem_ready = (c == 1 || c == 2 || c == 6 || c == 7 || c == 8) ? 1'b0 : 1'b1;
      #1;
      if (bus.ir_write === 1'b1) ir_cnt++;
      if (bus.instr_done === 1'b1) begin
        done_cnt++; done_c = c; mtr = bus.mem_to_reg;
      end
      if (c == 1) begin
        total++;
        if ({bus.mem_read, bus.ir_write, bus.pc_write} !== 3'b100) begin
          bad++; $display("FAIL lw_fetch_wait got=%b exp=100",
                          {bus.mem_read, bus.ir_write, bus.pc_write});
        end
      end
      if (c == 7) begin
        total++;
        if (dbg_state !== ST_MEM_RD || {bus.mem_read, bus.i_or_d} !== 2'b11) begin
          bad++; $display("FAIL lw_mem_rd state=%0d bits=%b exp state=%0d bits=11",
                          dbg_state, {bus.mem_read, bus.i_or_d}, ST_MEM_RD);
        end
      end
      tick();
    end
    total++;
    if (done_cnt !== 1 || done_c !== 10) begin
      bad++; $display("FAIL lw_latency count=%0d cycle=%0d exp count=1 cycle=10", done_cnt, done_c);
    end
    total++;
    if (ir_cnt !== 1) begin
      bad++; $display("FAIL lw_ir_write_count got=%0d exp=1", ir_cnt);
    end
    total++;
    if (mtr !== 1'b1) begin
      bad++; $display("FAIL lw_mem_to_reg got=%b exp=1", mtr);
    end
  endtask

  task automatic test_back_to_back();
    int done_cnt = 0;
    bus.mem_ready = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      bus.op = (c <= 3) ? OP_BEQ : OP_J;
      #1;
      if (bus.instr_done === 1'b1) done_cnt++;
      if (c == 3) begin
        total++;
        if (dbg_state !== ST_BRANCH ||
            {bus.pc_write_cond, bus.pc_write, bus.pc_source, bus.alu_op} !== 6'b100101) begin
          bad++; $display("FAIL beq_branch state=%0d bits=%b exp state=%0d bits=100101", dbg_state,
                          {bus.pc_write_cond, bus.pc_write, bus.pc_source, bus.alu_op}, ST_BRANCH);
        end
      end
      if (c == 6) begin
        total++;
        if (dbg_state !== ST_JUMP ||
            {bus.pc_write, bus.pc_write_cond, bus.pc_source} !== 4'b1010) begin
          bad++; $display("FAIL j_jump state=%0d bits=%b exp state=%0d bits=1010", dbg_state,
                          {bus.pc_write, bus.pc_write_cond, bus.pc_source}, ST_JUMP);
        end
      end
      tick();
    end
    total++;
    if (done_cnt !== 2) begin
      bad++; $display("FAIL beq_j_done_count got=%0d exp=2", done_cnt);
    end
  endtask

  task automatic test_ori_addi();
    logic [5:0] op_tab [1:8];
    op_tab[1] = OP_ADDI; op_tab[2] = OP_ORI;  op_tab[3] = OP_ADDI; op_tab[4] = OP_R;
    op_tab[5] = OP_ORI;  op_tab[6] = OP_ADDI; op_tab[7] = OP_ORI;  op_tab[8] = OP_ORI;
    bus.mem_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      bus.op = op_tab[c];
      #1;
      if (c == 3) begin
        total++;
        if (dbg_state !== ST_EXEC_I || {bus.alu_op, bus.alu_sel, bus.alu_src_b} !== 5'b11110) begin
          bad++; $display("FAIL ori_exec state=%0d bits=%b exp state=%0d bits=11110",
                          dbg_state, {bus.alu_op, bus.alu_sel, bus.alu_src_b}, ST_EXEC_I);
        end
      end
      if (c == 4) begin
        total++;
        if ({bus.reg_write, bus.reg_dst, bus.instr_done} !== 3'b101) begin
          bad++; $display("FAIL ori_wb got=%b exp=101", {bus.reg_write, bus.reg_dst, bus.instr_done});
        end
      end
      if (c == 7) begin
        total++;
        if (dbg_state !== ST_EXEC_I || {bus.alu_op, bus.alu_sel} !== 3'b110) begin
          bad++; $display("FAIL addi_exec state=%0d bits=%b exp state=%0d bits=110",
                          dbg_state, {bus.alu_op, bus.alu_sel}, ST_EXEC_I);
        end
      end
      if (c == 8) begin
        total++;
        if (dbg_state !== ST_I_WB || bus.instr_done !== 1'b1) begin
          bad++; $display("FAIL addi_wb state=%0d done=%b exp state=%0d done=1",
                          dbg_state, bus.instr_done, ST_I_WB);
        end
      end
      tick();
    end
  endtask

  task automatic test_illegal();
    int ill_cnt = 0;
    bus.op = 6'b111111;
    bus.mem_ready = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #1;
      if (bus.illegal_op === 1'b1) ill_cnt++;
      if (c == 3) begin
        total++;
        if (dbg_state !== ST_ILLEGAL || {bus.illegal_op, bus.instr_done} !== 2'b11) begin
          bad++; $display("FAIL illegal_pulse state=%0d bits=%b exp state=%0d bits=11",
                          dbg_state, {bus.illegal_op, bus.instr_done}, ST_ILLEGAL);
        end
        total++;
        if ({bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.mem_write, bus.ir_write} !== 5'b0) begin
          bad++; $display("FAIL illegal_no_writes got=%b exp=00000",
                          {bus.pc_write, bus.pc_write_cond, bus.reg_write, bus.mem_write, bus.ir_write});
        end
      end
      tick();
    end
    total++;
    if (ill_cnt !== 1) begin
      bad++; $display("FAIL illegal_count got=%0d exp=1", ill_cnt);
    end
    total++;
    if (dbg_state !== ST_FETCH) begin
      bad++; $display("FAIL illegal_to_fetch got=%0d exp=%0d", dbg_state, ST_FETCH);
    end
  endtask

  task automatic test_sw();
    int done_cnt = 0;
    int done_c = 0;
    for (int c = 1; c <= 4; c++) begin
      bus.op = OP_SW;
      bus.mem_ready = (c == 2 || c == 3) ? 1'b0 : 1'b1;
      #1;
      if (bus.instr_done === 1'b1) begin
        done_cnt++; done_c = c;
      end
      if (c == 4) begin
        total++;
        if (dbg_state !== ST_MEM_WR ||
            {bus.mem_write, bus.i_or_d, bus.mem_read, bus.instr_done} !== 4'b1101) begin
          bad++; $display("FAIL sw_mem_wr state=%0d bits=%b exp state=%0d bits=1101", dbg_state,
                          {bus.mem_write, bus.i_or_d, bus.mem_read, bus.instr_done}, ST_MEM_WR);
        end
      end
      tick();
    end
    total++;
    if (done_cnt !== 1 || done_c !== 4) begin
      bad++; $display("FAIL sw_latency count=%0d cycle=%0d exp count=1 cycle=4", done_cnt, done_c);
    end
    total++;
    if (dbg_state !== ST_FETCH) begin
      bad++; $display("FAIL sw_to_fetch got=%0d exp=%0d", dbg_state, ST_FETCH);
    end
  endtask

  task automatic test_reset_mid_write();
    for (int c = 1; c <= 5; c++) begin
      bus.op = OP_SW;
      bus.mem_ready = (c >= 4) ? 1'b0 : 1'b1;
      if (c == 5) rst = 1'b1;
      #1;
      if (c == 4 || c == 5) begin
        total++;
        if (dbg_state !== ST_MEM_WR || {bus.mem_write, bus.instr_done} !== 2'b10) begin
          bad++; $display("FAIL sw_hold c=%0d state=%0d bits=%b exp state=%0d bits=10",
                          c, dbg_state, {bus.mem_write, bus.instr_done}, ST_MEM_WR);
        end
      end
      tick();
    end
    total++;
    if (dbg_state !== ST_INIT) begin
      bad++; $display("FAIL rst_mid_wr_state got=%0d exp=%0d", dbg_state, ST_INIT);
    end
    total++;
    if (all_outs !== 19'h0) begin
      bad++; $display("FAIL rst_mid_wr_outs got=%h exp=0", all_outs);
    end
    rst = 1'b0;
    tick();
    total++;
    if (dbg_state !== ST_FETCH) begin
      bad++; $display("FAIL rst_recover got=%0d exp=%0d", dbg_state, ST_FETCH);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.op = '0;
    bus.mem_ready = 1'b0;
    test_reset();
    test_r_type();
    test_lw_waits();
    test_back_to_back();
    test_ori_addi();
    test_illegal();
    test_sw();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
